// File: rtl/led_pwm_mmap_pkg.sv
// Shared register offsets, CTRL bit positions and the CTRL struct for the LED PWM controller.
package led_pwm_pkg;

  localparam int unsigned LED_DIRECT    = 0;
  localparam int unsigned LED_CTRL      = 1;
  localparam int unsigned LED_PRESCALE  = 2;
  localparam int unsigned LED_BLINK     = 3;
  localparam int unsigned LED_DUTY_BASE = 4;

  localparam int unsigned CTRL_PWM_EN   = 0;
  localparam int unsigned CTRL_PWM_MODE = 1;

  // Field order matches the CTRL register layout: bit 1 = pwm_mode, bit 0 = pwm_en.
  typedef struct packed {
    logic pwm_mode;
    logic pwm_en;
  } ctrl_t;

endpackage

// File: rtl/led_pwm_mmap_if.sv
// Core data bus as seen by memory-mapped peripherals (word address, combinational read data).
interface led_pwm_mmap_if;
  logic        re;
  logic [31:0] rd;
  logic        we;
  logic [31:0] wd;
  logic [29:0] addr;

  modport master (output re, we, wd, addr, input rd);
  modport slave  (input re, we, wd, addr, output rd);
endinterface

// File: rtl/led_pwm_mmap_channel.sv
// One LED channel: duty register, PWM compare, blink gating and the registered LED output.
module led_pwm_channel #(
  parameter int unsigned PWM_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             duty_we_i,
  input  logic [PWM_W-1:0] duty_wd_i,
  input  logic [PWM_W-1:0] pwm_cnt_i,
  input  logic             pwm_mode_i,
  input  logic             pwm_en_i,
  input  logic             direct_i,
  input  logic             blank_i,
  output logic [PWM_W-1:0] duty_o,
  output logic             led_o
);

  logic [PWM_W-1:0] duty_q, duty_d;
  logic             led_q, led_d;

  always_comb begin
    duty_d = duty_we_i ? duty_wd_i : duty_q;
    if (pwm_mode_i) begin
      led_d = pwm_en_i && (pwm_cnt_i < duty_q);
    end else begin
      led_d = direct_i;
    end
    led_d = led_d && !blank_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      duty_q <= '0;
      led_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      led_q  <= led_d;
    end
  end

  assign duty_o = duty_q;
  assign led_o  = led_q;

endmodule

// File: rtl/led_pwm_mmap.sv
// Memory-mapped LED controller: direct or PWM drive per channel, with prescaler and PWM counter.
// Optional blink gating is built only when LED_PWM_BLINK_EN is defined.
module led_pwm_mmap
  import led_pwm_pkg::*;
#(
  parameter int unsigned NUM_LEDS = 8,
  parameter int unsigned PWM_W    = 8,
  parameter int unsigned PRESC_W  = 16,
  parameter int unsigned BLINK_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  output logic [NUM_LEDS-1:0] led,
  led_pwm_mmap_if.slave       bus
);

  logic [3:0]          offset;
  logic                wr_direct, wr_ctrl, wr_presc, wr_blink;
  logic [NUM_LEDS-1:0] direct_q, direct_d;
  ctrl_t               ctrl_q, ctrl_d;
  logic [PRESC_W-1:0]  prescale_q, prescale_d;
  logic [PRESC_W-1:0]  presc_cnt_q, presc_cnt_d;
  logic [PWM_W-1:0]    pwm_cnt_q, pwm_cnt_d;
  logic                tick, pwm_wrap;
  logic [NUM_LEDS-1:0] blank;
  logic [PWM_W-1:0]    duty [NUM_LEDS];

  assign offset    = bus.addr[3:0];
  assign wr_direct = bus.we && (offset == 4'(LED_DIRECT));
  assign wr_ctrl   = bus.we && (offset == 4'(LED_CTRL));
  assign wr_presc  = bus.we && (offset == 4'(LED_PRESCALE));
  assign wr_blink  = bus.we && (offset == 4'(LED_BLINK));

  assign tick     = (presc_cnt_q == prescale_q);
  assign pwm_wrap = tick && ctrl_q.pwm_en && (pwm_cnt_q == {PWM_W{1'b1}});

  always_comb begin
    direct_d    = wr_direct ? bus.wd[NUM_LEDS-1:0] : direct_q;
    ctrl_d      = wr_ctrl ? ctrl_t'(bus.wd[1:0]) : ctrl_q;
    prescale_d  = wr_presc ? bus.wd[PRESC_W-1:0] : prescale_q;
    presc_cnt_d = (wr_presc || tick) ? '0 : presc_cnt_q + 1'b1;
    pwm_cnt_d   = pwm_cnt_q;
    // Enabling the PWM restarts the period from zero.
    if (wr_ctrl && bus.wd[CTRL_PWM_EN] && !ctrl_q.pwm_en) begin
      pwm_cnt_d = '0;
    end else if (tick && ctrl_q.pwm_en) begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      direct_q    <= '0;
      ctrl_q      <= '0;
      prescale_q  <= '0;
      presc_cnt_q <= '0;
      pwm_cnt_q   <= '0;
    end else begin
      direct_q    <= direct_d;
      ctrl_q      <= ctrl_d;
      prescale_q  <= prescale_d;
      presc_cnt_q <= presc_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
    end
  end

`ifdef LED_PWM_BLINK_EN
  logic [BLINK_W-1:0]  blink_div_q, blink_div_d, blink_cnt_q, blink_cnt_d;
  logic [NUM_LEDS-1:0] blink_mask_q, blink_mask_d;
  logic                blink_phase_q, blink_phase_d;

  always_comb begin
    blink_div_d   = blink_div_q;
    blink_mask_d  = blink_mask_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (wr_blink) begin
      blink_div_d   = bus.wd[16 +: BLINK_W];
      blink_mask_d  = bus.wd[NUM_LEDS-1:0];
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (pwm_wrap) begin
      if (blink_cnt_q >= blink_div_q) begin
        blink_cnt_d   = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_div_q   <= '0;
      blink_mask_q  <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_div_q   <= blink_div_d;
      blink_mask_q  <= blink_mask_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign blank = blink_mask_q & {NUM_LEDS{!blink_phase_q}};
`else
  logic unused_blink;
  assign unused_blink = wr_blink ^ pwm_wrap;
  assign blank        = '0;
`endif

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    // Channels beyond offset 15 have no address and keep duty 0.
    localparam bit Mapped = (LED_DUTY_BASE + i) < 16;
    logic duty_we;
    assign duty_we = Mapped && bus.we && (offset == 4'((LED_DUTY_BASE + i) % 16));

    led_pwm_channel #(.PWM_W(PWM_W)) u_chan (
      .clk_i      (clk),
      .reset_i    (reset),
      .duty_we_i  (duty_we),
      .duty_wd_i  (bus.wd[PWM_W-1:0]),
      .pwm_cnt_i  (pwm_cnt_q),
      .pwm_mode_i (ctrl_q.pwm_mode),
      .pwm_en_i   (ctrl_q.pwm_en),
      .direct_i   (direct_q[i]),
      .blank_i    (blank[i]),
      .duty_o     (duty[i]),
      .led_o      (led[i])
    );
  end

  always_comb begin
    bus.rd = '0;
    if (bus.re) begin
      case (offset)
        4'(LED_DIRECT):   bus.rd[NUM_LEDS-1:0] = direct_q;
        4'(LED_CTRL):     bus.rd[1:0] = ctrl_q;
        4'(LED_PRESCALE): bus.rd[PRESC_W-1:0] = prescale_q;
`ifdef LED_PWM_BLINK_EN
        4'(LED_BLINK): begin
          bus.rd[16 +: BLINK_W]  = blink_div_q;
          bus.rd[NUM_LEDS-1:0]   = blink_mask_q;
        end
`endif
        default: begin
          for (int i = 0; i < NUM_LEDS; i++) begin
            if ((LED_DUTY_BASE + i) < 16 && offset == 4'((LED_DUTY_BASE + i) % 16)) begin
              bus.rd[PWM_W-1:0] = duty[i];
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_pwm_mmap.sv
// Directed bench for led_pwm_mmap with default parameters (8 LEDs, 8-bit PWM).
module tb_led_pwm_mmap;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] led;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cnt0, cnt1, cnt2low;
  int         guard;

  led_pwm_mmap_if bus ();

  led_pwm_mmap u_dut (
    .clk   (clk),
    .reset (reset),
    .led   (led),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the capturing posedge.
  task automatic wr(input int off, input logic [31:0] data);
    bus.we   = 1'b1;
    bus.addr = 30'(off);
    bus.wd   = data;
    @(negedge clk);
    bus.we   = 1'b0;
    bus.wd   = '0;
  endtask

  task automatic rd_check(input string tag, input int off, input logic [31:0] exp);
    bus.re   = 1'b1;
    bus.addr = 30'(off);
    #1;
    check(tag, bus.rd, exp);
    bus.re   = 1'b0;
  endtask

  task automatic count_window(input int cycles);
    cnt0 = 0; cnt1 = 0; cnt2low = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      cnt0    += int'(led[0]);
      cnt1    += int'(led[1]);
      cnt2low += int'(!led[2]);
    end
  endtask

  initial begin
    reset    = 1'b1;
    bus.re   = 1'b0;
    bus.we   = 1'b0;
    bus.wd   = '0;
    bus.addr = '0;
    repeat (2) @(negedge clk);
    check("reset_led", 32'(led), 32'h0);
    rd_check("reset_direct", 0, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Direct mode: register at the write edge, led one edge later.
    wr(0, 32'h0000_00A5);
    check("direct_latency_n1", 32'(led), 32'h0);
    @(negedge clk);
    check("direct_led", 32'(led), 32'hA5);
    rd_check("direct_read", 0, 32'hA5);
    bus.addr = 30'd0;
    #1;
    check("rd_zero_when_re_low", bus.rd, 32'h0);

    wr(0, 32'hFFFF_FF5A);
    rd_check("direct_upper_ignored", 0, 32'h5A);
    @(negedge clk);
    check("direct_led_5a", 32'(led), 32'h5A);

    wr(12, 32'hFF);
    rd_check("unmapped_read", 12, 32'h0);
    rd_check("unmapped_read_15", 15, 32'h0);

    // PWM mode with the counter disabled forces every channel off.
    wr(1, 32'h2);
    @(negedge clk);
    check("mode1_en0_off", 32'(led), 32'h0);
    rd_check("ctrl_read_2", 1, 32'h2);

    wr(2, 32'h0);
    wr(4, 32'hFFFF_FF40);
    wr(5, 32'h0);
    wr(6, 32'hFF);
    rd_check("duty0_read", 4, 32'h40);
    rd_check("duty2_read", 6, 32'hFF);
    wr(1, 32'h3);
    @(negedge clk);
    check("pwm_start_led0", 32'(led[0]), 32'h1);
    rd_check("ctrl_read_3", 1, 32'h3);

    count_window(256);
    check("duty64_high_count", 32'(cnt0), 32'd64);
    check("duty0_high_count", 32'(cnt1), 32'd0);
    check("duty255_low_count", 32'(cnt2low), 32'd1);

    wr(2, 32'h3);
    rd_check("prescale_read", 2, 32'h3);
    count_window(1024);
    check("presc3_duty64_count", 32'(cnt0), 32'd256);
    check("presc3_duty0_count", 32'(cnt1), 32'd0);
    check("presc3_duty255_low", 32'(cnt2low), 32'd4);

    // Reset mid-period while led[0] is on.
    guard = 0;
    while (led[0] !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("led0_seen_high", 32'(led[0]), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_led", 32'(led), 32'h0);
    for (int off = 0; off < 8; off++) begin
      rd_check($sformatf("midreset_read_%0d", off), off, 32'h0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("after_reset_led", 32'(led), 32'h0);

`ifdef LED_PWM_BLINK_EN
    wr(4, 32'h40);
    wr(3, 32'h0001_0001);
    rd_check("blink_read", 3, 32'h0001_0001);
    wr(1, 32'h3);
    count_window(1024);
    check("blink_gated_count", 32'(cnt0), 32'd128);
`else
    wr(3, 32'h0001_0001);
    rd_check("blink_absent_read", 3, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
